// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
// Holds the default halt encoding, the fetch state enum, the queue
// entry layout and small PC arithmetic helpers.
package fetch_ctrl_pkg;

  // Encoding of the branch-to-self idiom that stops fetch.
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hEAFF_FFFE;

  // Sequential fetch stride and word-alignment mask.
  localparam logic [31:0] PC_STEP       = 32'h0000_0004;
  localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Next sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of fetched {pc, instr} entries.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             empties the queue (pointers and count to zero)
//   push, push_pc,
//   push_instr        write one entry at the write pointer
//   pop               retire the head entry (caller guarantees non-empty)
//   head_pc,
//   head_instr        entry at the read pointer
//   count, full,
//   empty             occupancy status
module fetch_queue
  import fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  input  logic             pop,
  output logic [31:0]      head_pc,
  output logic [31:0]      head_instr,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fetch_entry_t     mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage, pointers and occupancy; DEPTH is a power of two so the
  // pointers wrap naturally.  Simultaneous push/pop leaves count as is,
  // and a push while full is only issued together with a pop, in which
  // case the written slot is the one being retired.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= fetch_entry_t'{pc: push_pc, instr: push_instr};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_pc    = mem_r[rd_ptr_r].pc;
  assign head_instr = mem_r[rd_ptr_r].instr;
  assign count      = count_r;
  assign full       = (count_r == CNT_MAX);
  assign empty      = (count_r == '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Owns the fetch PC, presents it to a combinational instruction memory
// every cycle and buffers fetched words in fetch_queue for decode.
// Ports:
//   CLK, RESET_N     clock, synchronous active-low reset
//   IMEM_A, IMEM_RD  fetch address / combinational instruction word
//   INSTR, INSTR_PC  head-of-queue instruction and its address
//   INSTR_VALID,
//   INSTR_READY      decode handshake
//   REDIRECT,
//   REDIRECT_PC      flush queue and restart fetch at a new address
//   HALTED           halt word consumed and queue drained
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int          DEPTH     = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] IMEM_A,
  input  logic [31:0] IMEM_RD,
  output logic [31:0] INSTR,
  output logic [31:0] INSTR_PC,
  output logic        INSTR_VALID,
  input  logic        INSTR_READY,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        HALTED
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_e     state_r;
  logic [31:0]      fpc_r;
  logic [CNT_W-1:0] q_count_s;
  logic             q_full_s;
  logic             q_empty_s;
  logic             valid_s;
  logic             pop_s;
  logic             push_s;

  // A redirect masks the head so a same-cycle pop is never seen by decode.
  assign valid_s = (q_count_s != '0) && !REDIRECT;
  assign pop_s   = valid_s && INSTR_READY;
  // A full queue still accepts a word when the head leaves in the same cycle.
  assign push_s  = (state_r == ST_RUN) && !REDIRECT && (!q_full_s || pop_s);

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .flush      (REDIRECT),
    .push       (push_s),
    .push_pc    (fpc_r),
    .push_instr (IMEM_RD),
    .pop        (pop_s),
    .head_pc    (INSTR_PC),
    .head_instr (INSTR),
    .count      (q_count_s),
    .full       (q_full_s),
    .empty      (q_empty_s)
  );

  // Fetch state machine and fetch PC; reset beats redirect, redirect
  // beats sequential fetch.  The halt word itself is enqueued, so the
  // PC still steps past it before fetch stops.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_r <= ST_RUN;
      fpc_r   <= RESET_PC;
    end else if (REDIRECT) begin
      state_r <= ST_RUN;
      fpc_r   <= REDIRECT_PC & PC_ALIGN_MASK;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (push_s) begin
            fpc_r <= pc_plus4(fpc_r);
            if (IMEM_RD == HALT_WORD) begin
              state_r <= ST_HALT;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            fpc_r <= fpc_r;
          end
        end
        ST_HALT: begin
          state_r <= ST_HALT;
          fpc_r   <= fpc_r;
        end
        default: begin
          state_r <= ST_RUN;
          fpc_r   <= fpc_r;
        end
      endcase
    end
  end

  assign IMEM_A      = fpc_r;
  assign INSTR_VALID = valid_s;
  assign HALTED      = (state_r == ST_HALT) && q_empty_s;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl with a behavioural combinational imem
// holding a 12-word program ending in the halt idiom at 0x2C.
module tb_fetch_ctrl;

  localparam logic [31:0] DEFAULT_WORD = 32'hE1A0_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_a;
  logic [31:0] imem_rd;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halted;

  int n_vec;
  int n_bad;

  fetch_ctrl #(
    .DEPTH     (2),
    .RESET_PC  (32'h0000_0000),
    .HALT_WORD (32'hEAFF_FFFE)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .IMEM_A      (imem_a),
    .IMEM_RD     (imem_rd),
    .INSTR       (instr),
    .INSTR_PC    (instr_pc),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .REDIRECT    (redirect),
    .REDIRECT_PC (redirect_pc),
    .HALTED      (halted)
  );

  // Test program; anything outside 0x00..0x2C reads DEFAULT_WORD.
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    logic [31:0] w;
    w = DEFAULT_WORD;
    if (a[31:6] == 26'd0) begin
      case (a[5:2])
        4'd0:    w = 32'hE202_2000;
        4'd1:    w = 32'hE382_3000;
        4'd2:    w = 32'hE283_3005;
        4'd3:    w = 32'hE043_4002;
        4'd4:    w = 32'hE154_0003;
        4'd5:    w = 32'hE082_2004;
        4'd6:    w = 32'hE242_2001;
        4'd7:    w = 32'hE352_0000;
        4'd8:    w = 32'h1AFF_FFFB;
        4'd9:    w = 32'hE584_3000;
        4'd10:   w = 32'hE594_2000;
        4'd11:   w = 32'hEAFF_FFFE;
        default: w = DEFAULT_WORD;
      endcase
    end
    return w;
  endfunction

  assign imem_rd = imem_word(imem_a);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks a valid head entry against the expected address.
  task automatic check_head(input string tag, input logic [31:0] pc);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, "_pc"}, instr_pc, pc);
    check({tag, "_instr"}, instr, imem_word(pc));
  endtask

  // Holds reset across one rising edge; caller releases it.
  task automatic hold_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    tick();
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;

    // Reset state
    tick();
    tick();
    check("rst_imem_a", imem_a, 32'h0000_0000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_instr", instr, 32'h0000_0000);
    check("rst_instr_pc", instr_pc, 32'h0000_0000);

    // Streaming after reset release, one entry per cycle
    rst_n = 1'b1;
    #1;
    check("lat_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("s0_instr_lit", instr, 32'hE202_2000);
    check("s1_pc_lit_pre", imem_a, 32'h0000_0004);
    for (int i = 0; i < 6; i++) begin
      check_head($sformatf("stream%0d", i), 32'(i) * 32'd4);
      tick();
    end

    // Backpressure: queue fills to 2, fetch PC parks at 0x08
    hold_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        check($sformatf("bp_hold_a%0d", i), imem_a, 32'h0000_0008);
      end
    end
    check_head("bp_head", 32'h0000_0000);
    instr_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check_head($sformatf("bp_drain%0d", i), 32'(i) * 32'd4);
      tick();
    end

    // Redirect while full with ready high
    hold_reset();
    rst_n       = 1'b1;
    instr_ready = 1'b0;
    tick();
    tick();
    tick();
    instr_ready = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0017;
    #1;
    check("redir_valid_masked", {31'd0, instr_valid}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    check("redir_imem_a", imem_a, 32'h0000_0014);
    check("redir_empty", {31'd0, instr_valid}, 32'd0);
    tick();
    check("redir_instr_lit", instr, 32'hE082_2004);

    // Run on to the halt word at 0x2C
    for (int i = 0; i < 7; i++) begin
      check_head($sformatf("to_halt%0d", i), 32'h0000_0014 + 32'(i) * 32'd4);
      check($sformatf("to_halt%0d_halted", i), {31'd0, halted}, 32'd0);
      tick();
    end
    check("halt_valid", {31'd0, instr_valid}, 32'd0);
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_imem_a", imem_a, 32'h0000_0030);
    tick();
    tick();
    check("halt_hold_a", imem_a, 32'h0000_0030);
    check("halt_hold_h", {31'd0, halted}, 32'd1);

    // Redirect out of halt
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0000;
    tick();
    redirect = 1'b0;
    #1;
    check("unhalt_halted", {31'd0, halted}, 32'd0);
    check("unhalt_imem_a", imem_a, 32'h0000_0000);
    tick();
    check_head("unhalt_head", 32'h0000_0000);

    // Address wrap past 0xFFFF_FFFC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    check_head("wrap0", 32'hFFFF_FFF8);
    check("wrap0_instr_lit", instr, DEFAULT_WORD);
    tick();
    check_head("wrap1", 32'hFFFF_FFFC);
    tick();
    check_head("wrap2", 32'h0000_0000);
    tick();

    // Reset coincident with redirect, mid-stream
    rst_n       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0020;
    tick();
    rst_n    = 1'b1;
    redirect = 1'b0;
    #1;
    check("mrst_imem_a", imem_a, 32'h0000_0000);
    check("mrst_valid", {31'd0, instr_valid}, 32'd0);
    check("mrst_halted", {31'd0, halted}, 32'd0);
    check("mrst_instr", instr, 32'h0000_0000);
    check("mrst_instr_pc", instr_pc, 32'h0000_0000);
    tick();
    check_head("mrst_head", 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  // Watchdog so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
